clock_hms_counter: RTL and testbench

//   Time-of-day core, directly downstream of the seconds divider. Samples the divided
//   1 Hz clock (sec_in) in the 50 MHz domain and edge-detects it into a one-cycle tick.

---
 rtl/clock_pkg.sv | 29 ++
 rtl/bcd_wrap_counter.sv | 25 ++
 rtl/clock_hms_counter.sv | 111 +++++++++++
 tb/tb_clock_hms_counter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared BCD constants and helpers for the time-of-day core.
package clock_pkg;

  localparam int BCD8_W = 8;
  localparam logic [BCD8_W-1:0] BCD_SEC_MAX = 8'h59;
  localparam logic [BCD8_W-1:0] BCD_MIN_MAX = 8'h59;

  // Two-digit BCD increment; the caller handles wrap at its own maximum.
  function automatic logic [BCD8_W-1:0] bcd_inc(input logic [BCD8_W-1:0] v);
    logic [BCD8_W-1:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Both digits must be decimal; for valid BCD a binary compare orders correctly.
  function automatic logic bcd_legal(input logic [BCD8_W-1:0] v,
                                     input logic [BCD8_W-1:0] max);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
  endfunction

  function automatic logic [BCD8_W-1:0] bin_to_bcd8(input int v);
    logic [BCD8_W-1:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD counter wrapping MAX_BCD -> 00; wrap flags the terminal value.
module bcd_wrap_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       wrap
);

  // Terminal-count indicator, so the next inc in the chain can be gated off it.
  assign wrap = (value == MAX_BCD);

  always_ff @(posedge clk) begin
    if (rst)       value <= 8'h00;
    else if (load) value <= load_val;
    else if (inc)  value <= wrap ? 8'h00 : bcd_inc(value);
  end

endmodule

// File: rtl/clock_hms_counter.sv
// BCD hh:mm:ss time-of-day core: sec_in synchroniser/edge detector, validated
// time-set handshake, cascaded wrap counters and an hh:mm alarm compare.
module clock_hms_counter
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int HOURS_PER_DAY = 24
) (
  input  logic       clk_in_50M,
  input  logic       rst,
  input  logic       sec_in,
  input  logic       run,
  input  logic       set_valid,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_tick,
  output logic       min_carry,
  output logic       hour_carry,
  output logic       day_carry,
  output logic       set_ack,
  output logic       set_err,
  output logic       alarm_hit
);

  localparam logic [7:0] BCD_HOUR_MAX = bin_to_bcd8(HOURS_PER_DAY - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   hist_p1;
  logic                   edge_p1;

  logic       ss_wrap, mm_wrap, hh_wrap;
  logic       cnt, mm_inc, hh_inc;
  logic       set_ok, set_load;
  logic [7:0] mm_next, hh_next;
  logic       alarm_match;

  // ---- stage p0: synchroniser, preset high so a held-high sec_in cannot tick
  always_ff @(posedge clk_in_50M) begin
    if (rst) begin
      sync_p0 <= '1;
      hist_p1 <= 1'b1;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sec_in};
      hist_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  // ---- stage p1: rising-edge detect, registered into sec_tick
  assign edge_p1 = sync_p0[SYNC_STAGES-1] & ~hist_p1;

  always_ff @(posedge clk_in_50M) begin
    if (rst) sec_tick <= 1'b0;
    else     sec_tick <= edge_p1;
  end

  // A set request in the same cycle as a tick wins; the tick is dropped.
  assign set_ok   = bcd_legal(set_hh, BCD_HOUR_MAX) &&
                    bcd_legal(set_mm, BCD_MIN_MAX)  &&
                    bcd_legal(set_ss, BCD_SEC_MAX);
  assign set_load = set_valid & set_ok;
  assign cnt      = sec_tick & run & ~set_valid;
  assign mm_inc   = cnt & ss_wrap;
  assign hh_inc   = mm_inc & mm_wrap;

  bcd_wrap_counter #(.MAX_BCD(BCD_SEC_MAX)) u_ss (
    .clk(clk_in_50M), .rst(rst), .inc(cnt), .load(set_load),
    .load_val(set_ss), .value(ss), .wrap(ss_wrap)
  );

  bcd_wrap_counter #(.MAX_BCD(BCD_MIN_MAX)) u_mm (
    .clk(clk_in_50M), .rst(rst), .inc(mm_inc), .load(set_load),
    .load_val(set_mm), .value(mm), .wrap(mm_wrap)
  );

  bcd_wrap_counter #(.MAX_BCD(BCD_HOUR_MAX)) u_hh (
    .clk(clk_in_50M), .rst(rst), .inc(hh_inc), .load(set_load),
    .load_val(set_hh), .value(hh), .wrap(hh_wrap)
  );

  // Alarm compares against the post-tick time so the hit lines up with the new count.
  assign mm_next     = ss_wrap ? (mm_wrap ? 8'h00 : bcd_inc(mm)) : mm;
  assign hh_next     = (ss_wrap & mm_wrap) ? (hh_wrap ? 8'h00 : bcd_inc(hh)) : hh;
  assign alarm_match = alarm_en & ss_wrap & (mm_next == alarm_mm) & (hh_next == alarm_hh);

  // ---- stage p2: carry, alarm and set handshake pulses
  always_ff @(posedge clk_in_50M) begin
    if (rst) begin
      min_carry  <= 1'b0;
      hour_carry <= 1'b0;
      day_carry  <= 1'b0;
      alarm_hit  <= 1'b0;
      set_ack    <= 1'b0;
      set_err    <= 1'b0;
    end else begin
      min_carry  <= mm_inc;
      hour_carry <= hh_inc;
      day_carry  <= hh_inc & hh_wrap;
      alarm_hit  <= cnt & alarm_match;
      set_ack    <= set_valid;
      if (set_valid) set_err <= ~set_ok;
    end
  end

endmodule

// File: tb/tb_clock_hms_counter.sv
// Directed bench for clock_hms_counter: 24-hour instance plus a 12-hour build.
module tb_clock_hms_counter;

  logic       clk = 1'b0;
  logic       rst, sec_in, run, set_valid, alarm_en;
  logic [7:0] set_hh, set_mm, set_ss, alarm_hh, alarm_mm;
  logic [7:0] hh, mm, ss, hh2, mm2, ss2;
  logic       sec_tick, min_carry, hour_carry, day_carry, set_ack, set_err, alarm_hit;
  logic       sec_tick2, min_carry2, hour_carry2, day_carry2, set_ack2, set_err2, alarm_hit2;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  clock_hms_counter #(.SYNC_STAGES(2), .HOURS_PER_DAY(24)) dut (
    .clk_in_50M(clk), .rst(rst), .sec_in(sec_in), .run(run),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .hh(hh), .mm(mm), .ss(ss), .sec_tick(sec_tick), .min_carry(min_carry),
    .hour_carry(hour_carry), .day_carry(day_carry), .set_ack(set_ack),
    .set_err(set_err), .alarm_hit(alarm_hit)
  );

  clock_hms_counter #(.SYNC_STAGES(2), .HOURS_PER_DAY(12)) dut12 (
    .clk_in_50M(clk), .rst(rst), .sec_in(sec_in), .run(run),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .hh(hh2), .mm(mm2), .ss(ss2), .sec_tick(sec_tick2), .min_carry(min_carry2),
    .hour_carry(hour_carry2), .day_carry(day_carry2), .set_ack(set_ack2),
    .set_err(set_err2), .alarm_hit(alarm_hit2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_time(input string tag, input logic [23:0] exp);
    chk(tag, {hh, mm, ss}, exp);
  endtask

  // Drive a one-cycle set request; returns just after the edge that loads it.
  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_hh = h; set_mm = m; set_ss = s;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
  endtask

  // Raise sec_in and stop in the cycle where sec_tick is visible.
  task automatic rise_until_tick();
    int n;
    sec_in = 1'b1;
    n = 0;
    while (sec_tick !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    if (sec_tick !== 1'b1) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic drop_sec();
    sec_in = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int ticks;
    rst = 1'b1; sec_in = 1'b1; run = 1'b0; set_valid = 1'b0;
    set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00;
    alarm_en = 1'b0; alarm_hh = 8'h00; alarm_mm = 8'h00;
    repeat (3) step();
    rst = 1'b0;

    // sec_in held high through reset: no tick after release
    ticks = 0;
    repeat (10) begin
      step();
      if (sec_tick === 1'b1) ticks++;
    end
    chk("rst_no_tick", ticks, 0);
    chk_time("rst_time", 24'h000000);
    chk("rst_pulses", {min_carry, hour_carry, day_carry, set_ack, set_err, alarm_hit}, 6'b0);
    drop_sec();

    // Day rollover from 23:59:58
    set_time(8'h23, 8'h59, 8'h58);
    chk("set1_ack", set_ack, 1'b1);
    chk_time("set1_time", 24'h235958);
    run = 1'b1;
    step();
    rise_until_tick();
    step();
    chk_time("tick_2359_59", 24'h235959);
    chk("no_carry_59", {min_carry, hour_carry, day_carry}, 3'b000);
    drop_sec();
    rise_until_tick();
    step();
    chk_time("rollover_time", 24'h000000);
    chk("rollover_carries", {min_carry, hour_carry, day_carry}, 3'b111);
    step();
    chk("carries_one_cycle", {min_carry, hour_carry, day_carry}, 3'b000);
    drop_sec();

    // Illegal set then legal set
    set_time(8'h1A, 8'h00, 8'h00);
    chk("bad_set_ack", set_ack, 1'b1);
    chk("bad_set_err", set_err, 1'b1);
    chk_time("bad_set_time", 24'h000000);
    step();
    chk("ack_one_cycle", set_ack, 1'b0);
    chk("err_holds", set_err, 1'b1);
    set_time(8'h12, 8'h00, 8'h00);
    chk("good_set_err", set_err, 1'b0);
    chk_time("good_set_time", 24'h120000);
    step();

    // Set collides with a counting tick: load wins
    set_time(8'h10, 8'h20, 8'h30);
    step();
    rise_until_tick();
    set_time(8'h05, 8'h06, 8'h07);
    chk_time("collide_load", 24'h050607);
    step();
    chk_time("collide_no_inc", 24'h050607);
    drop_sec();

    // Alarm on tick-driven advance, not on load
    alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_en = 1'b1;
    set_time(8'h07, 8'h29, 8'h59);
    chk("alarm_not_on_set", alarm_hit, 1'b0);
    step();
    rise_until_tick();
    step();
    chk_time("alarm_time", 24'h073000);
    chk("alarm_hit", alarm_hit, 1'b1);
    step();
    chk("alarm_one_cycle", alarm_hit, 1'b0);
    drop_sec();
    set_time(8'h07, 8'h30, 8'h00);
    chk("alarm_reload_none", alarm_hit, 1'b0);
    step();
    chk("alarm_reload_none2", alarm_hit, 1'b0);

    // run=0: ticks still seen, time frozen
    run = 1'b0;
    ticks = 0;
    for (int i = 0; i < 5; i++) begin
      sec_in = 1'b1;
      repeat (5) begin
        step();
        if (sec_tick === 1'b1) ticks++;
      end
      sec_in = 1'b0;
      repeat (4) step();
    end
    chk("hold_ticks", ticks, 5);
    chk_time("hold_time", 24'h073000);
    chk("hold_carry", min_carry, 1'b0);

    // 12-hour build wraps 11:59:59 -> 00:00:00
    run = 1'b1;
    alarm_en = 1'b0;
    set_time(8'h11, 8'h59, 8'h59);
    chk("h12_set_err", set_err2, 1'b0);
    step();
    rise_until_tick();
    step();
    chk("h12_wrap_time", {hh2, mm2, ss2}, 24'h000000);
    chk("h12_day_carry", day_carry2, 1'b1);
    chk_time("h24_to_noon", 24'h120000);
    chk("h24_no_day_carry", {hour_carry, day_carry}, 2'b10);
    drop_sec();

    // Reset mid-count clears time and pulses
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_time("midrst_time", 24'h000000);
    chk("midrst_pulses", {min_carry, hour_carry, day_carry, set_ack, set_err, alarm_hit}, 6'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
